// File: rtl/imm_decode_stage.sv
// Decode stage for RV32 immediates: a 2-entry FIFO that decodes format/immediate at push
// and presents the head entry from registers, decoupling fetch from execute.
module imm_decode_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_imm,
  output logic [2:0]  out_fmt,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_illegal
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FMT_W = 3;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [FMT_W-1:0] FMT_I    = FMT_W'(0);
  localparam logic [FMT_W-1:0] FMT_S    = FMT_W'(1);
  localparam logic [FMT_W-1:0] FMT_B    = FMT_W'(2);
  localparam logic [FMT_W-1:0] FMT_U    = FMT_W'(3);
  localparam logic [FMT_W-1:0] FMT_J    = FMT_W'(4);
  localparam logic [FMT_W-1:0] FMT_Z    = FMT_W'(5);
  localparam logic [FMT_W-1:0] FMT_NONE = FMT_W'(6);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam entry_t RESET_ENTRY = '{
    imm:     '0,
    fmt:     FMT_NONE,
    pc:      '0,
    instr:   '0,
    illegal: 1'b0
  };

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  entry_t           mem [DEPTH];
  entry_t           out_q;
  entry_t           dec_c;
  logic             push_c;
  logic             pop_c;
  logic             load_new_c;
  logic             load_next_c;

  // Format selection and immediate assembly for one raw instruction word.
  function automatic entry_t decode(input logic [XLEN-1:0] instr, input logic [XLEN-1:0] pc);
    entry_t e;
    e.pc      = pc;
    e.instr   = instr;
    e.illegal = 1'b0;
    e.fmt     = FMT_NONE;
    e.imm     = '0;
    case (instr[6:0])
      7'b0000011, 7'b0010011, 7'b0001111, 7'b1100111: e.fmt = FMT_I;
      7'b0100011:             e.fmt = FMT_S;
      7'b1100011:             e.fmt = FMT_B;
      7'b0110111, 7'b0010111: e.fmt = FMT_U;
      7'b1101111:             e.fmt = FMT_J;
      7'b1110011:             e.fmt = instr[14] ? FMT_Z : FMT_I;
      7'b0110011:             e.fmt = FMT_NONE;
      default:                e.illegal = 1'b1;
    endcase
    case (e.fmt)
      FMT_I: e.imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S: e.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: e.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: e.imm = {instr[31:12], 12'b0};
      FMT_J: e.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_Z: e.imm = {27'b0, instr[19:15]};
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  assign dec_c  = decode(in_instr, in_pc);

  // Readiness is gated by reset so nothing is accepted while the block is held in reset.
  assign in_ready  = resetn && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push_c    = in_valid && in_ready && !flush;
  assign pop_c     = out_valid && out_ready && !flush;

  // The output register takes a fresh word when it becomes head straight away,
  // or the second buffered word when the head leaves a full buffer.
  assign load_new_c  = push_c && ((state == EMPTY) || ((state == ONE) && pop_c));
  assign load_next_c = pop_c && (state == FULL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push_c) state_nxt = ONE;
        ONE: begin
          if (push_c && !pop_c) begin
            state_nxt = FULL;
          end else if (pop_c && !push_c) begin
            state_nxt = EMPTY;
          end
        end
        FULL:    if (pop_c) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push_c) tail <= tail + PTR_W'(1);
      if (pop_c)  head <= head + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= RESET_ENTRY;
    end else if (push_c) begin
      mem[tail] <= dec_c;
    end
  end

  // Head entry register: holds across stalls, flushes and empty periods.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q <= RESET_ENTRY;
    end else if (load_new_c) begin
      out_q <= dec_c;
    end else if (load_next_c) begin
      out_q <= mem[head + PTR_W'(1)];
    end
  end

  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_pc      = out_q.pc;
  assign out_instr   = out_q.instr;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: directed scenarios plus random traffic,
// expectations produced by an arithmetic reference decoder.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_illegal;

  imm_decode_stage #(.DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_pc(out_pc), .out_instr(out_instr), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decoder: field values assembled arithmetically, sign applied as a subtraction.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    int s;
    logic [6:0] op;
    s = $signed(i);
    op = i[6:0];
    e.pc = pc; e.instr = i; e.ill = 1'b0; e.imm = '0;
    if (op == 7'h03 || op == 7'h13 || op == 7'h0F || op == 7'h67) e.fmt = 3'd0;
    else if (op == 7'h23) e.fmt = 3'd1;
    else if (op == 7'h63) e.fmt = 3'd2;
    else if (op == 7'h37 || op == 7'h17) e.fmt = 3'd3;
    else if (op == 7'h6F) e.fmt = 3'd4;
    else if (op == 7'h73) e.fmt = i[14] ? 3'd5 : 3'd0;
    else if (op == 7'h33) e.fmt = 3'd6;
    else begin e.fmt = 3'd6; e.ill = 1'b1; end
    case (e.fmt)
      3'd0: e.imm = 32'(s >>> 20);
      3'd1: e.imm = 32'(((s >>> 25) * 32) + int'(i[11:7]));
      3'd2: e.imm = 32'(int'({i[7], i[30:25], i[11:8], 1'b0}) - (i[31] ? 4096 : 0));
      3'd3: e.imm = i & 32'hFFFFF000;
      3'd4: e.imm = 32'(int'({i[19:12], i[20], i[30:21], 1'b0}) - (i[31] ? 1048576 : 0));
      3'd5: e.imm = (i >> 15) & 32'h1F;
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  // Monitor: checks occupancy and head contents, then tracks the edge about to happen.
  always @(negedge clk) begin
    if (resetn) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (out_valid && q.size() > 0) begin
        chk("out_imm", out_imm, q[0].imm);
        chk("out_fmt", 32'(out_fmt), 32'(q[0].fmt));
        chk("out_pc", out_pc, q[0].pc);
        chk("out_instr", out_instr, q[0].instr);
        chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy; flush = fl;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_imm"}, out_imm, 32'd0);
    chk({tag, "_out_fmt"}, 32'(out_fmt), 32'd6);
    chk({tag, "_out_pc"}, out_pc, 32'd0);
    chk({tag, "_out_instr"}, out_instr, 32'd0);
    chk({tag, "_out_illegal"}, 32'(out_illegal), 32'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    @(posedge clk);
    #2;
    resetn = 1'b0;
    q.delete();
    #1;
    check_reset_values("rst_pulse");
    #1;
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h0F, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
    w = $urandom();
    if ($urandom_range(0, 5) == 0) w[6:0] = 7'h33;
    else if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc;
    pc = 32'h1000;
    #2 resetn = 1'b0;
    #1 check_reset_values("reset");
    #19 resetn = 1'b1;
    #1 chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // addi x1,x0,-1 then a back-to-back mix of U/J/B/Z words, then two illegal words
    drive(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    drive(1'b1, 32'h12345037, 32'h104, 1'b1, 1'b0);
    drive(1'b1, 32'hFFDFF06F, 32'h108, 1'b1, 1'b0);
    drive(1'b1, 32'hFE000CE3, 32'h10C, 1'b1, 1'b0);
    drive(1'b1, 32'h3002D073, 32'h110, 1'b1, 1'b0);
    drive(1'b1, 32'h0000007F, 32'h114, 1'b1, 1'b0);
    drive(1'b1, 32'h00000000, 32'h118, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: third word waits upstream until the stall releases
    drive(1'b1, 32'h00A00113, 32'h200, 1'b0, 1'b0);
    drive(1'b1, 32'h00112223, 32'h204, 1'b0, 1'b0);
    drive(1'b1, 32'hFE20CEE3, 32'h208, 1'b0, 1'b0);
    drive(1'b1, 32'hFE20CEE3, 32'h208, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while full with a word on offer
    drive(1'b1, 32'h00000517, 32'h300, 1'b0, 1'b0);
    drive(1'b1, 32'h0040006F, 32'h304, 1'b0, 1'b0);
    drive(1'b1, 32'hDEADB0B7, 32'h308, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset pulse while one entry is held, then a single push afterwards
    drive(1'b1, 32'h00C58593, 32'h400, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset_pulse();
    drive(1'b1, 32'h34202573, 32'h404, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional flushes and reset pulses
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_pulse();
      end else begin
        drive($urandom_range(0, 3) != 0, rand_instr(), pc,
              $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        pc = pc + 32'd4;
      end
    end
    for (int n = 0; n < 4; n++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of buffer entries (fixed at 2 for this release).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port resetn, input, 1, reset (asynchronous, active-low).
REQ-004 The block SHALL have port flush, input, 1, which discards all buffered entries.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream fetch offers an instruction.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the offered instruction this cycle.
REQ-007 The block SHALL have port in_instr, input, 32, the raw RV32 instruction word.
REQ-008 The block SHALL have port in_pc, input, 32, the PC of in_instr.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the head entry is presented.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the downstream stage consumes the head entry.
REQ-011 The block SHALL have port out_imm, output, 32, the extended immediate.
REQ-012 The block SHALL have port out_fmt, output, 3, the immediate format code.
REQ-013 The block SHALL have port out_pc, output, 32, the PC of the head entry.
REQ-014 The block SHALL have port out_instr, output, 32, the raw instruction of the head entry.
REQ-015 The block SHALL have port out_illegal, output, 1, meaning the opcode is unsupported.

Function
REQ-016 The block SHALL be a 2-entry FIFO with state count in {EMPTY=0, ONE=1, FULL=2}.
REQ-017 Push: in_valid && in_ready at the clock edge; the block SHALL decode the format and immediate and store them in the entry at that edge.
REQ-018 Pop: out_valid && out_ready at the clock edge.
REQ-019 in_ready SHALL equal (count != FULL) and SHALL NOT depend combinationally on out_ready or in_valid.
REQ-020 out_valid SHALL equal (count != EMPTY); all out_* SHALL come from registered head-entry fields, with no combinational path from in_* to out_*.
REQ-021 Latency SHALL be one cycle: an instruction pushed at edge N is presented at out_* after edge N when the buffer was EMPTY.
REQ-022 Transitions: push only, count+1; pop only, count-1; push and pop in ONE, count stays ONE with the new entry becoming head after the old one leaves; push and pop in FULL SHALL be impossible, since in_ready=0.
REQ-023 Order SHALL be strictly FIFO; head and tail pointers SHALL wrap modulo 2.
REQ-024 flush=1 SHALL set count to EMPTY at the edge, drop any simultaneous push or pop, and take priority over both.
REQ-025 When out_valid=1 and out_ready=0, all out_* SHALL be held stable.
REQ-026 Format codes: I=0, S=1, B=2, U=3, J=4, Z=5, NONE=6; the value 7 SHALL never be produced.
REQ-027 Opcode decode on in_instr[6:0]:
- 0000011, 0010011, 0001111, 1100111 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- 1110011 -> Z if funct3[2]=1, else I
- 0110011 -> NONE
REQ-028 Any other opcode, including instr[1:0] != 11, SHALL give fmt=NONE, imm=0, illegal=1; every listed opcode SHALL give illegal=0.
REQ-029 The immediates SHALL be formed as follows:
- I = sext(instr[31:20])
- S = sext({instr[31:25], instr[11:7]})
- B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
- U = {instr[31:12], 12'b0}
- J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
- Z = zext(instr[19:15])
- NONE = 0
REQ-030 Sign extension SHALL replicate instr[31] into every upper bit up to bit 31.
REQ-031 When out_valid=0, out_* SHALL hold their last value, with no requirement on that value.

Reset
REQ-032 resetn=0 SHALL immediately, without waiting for a clock edge, force count=EMPTY and head/tail pointers=0.
REQ-033 resetn=0 SHALL immediately force out_valid=0, out_imm=0, out_fmt=6, out_pc=0, out_instr=0, out_illegal=0.
REQ-034 While resetn=0, in_ready SHALL be 0.
REQ-035 Deassertion of resetn SHALL be synchronized externally; in_ready SHALL be 1 on the first edge after deassertion.
REQ-036 Reset asserted mid-operation SHALL discard all entries, and no partial entry SHALL be visible afterwards.

Verification
REQ-037 Push 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=0, out_illegal=0.
REQ-038 Push in consecutive cycles 0x12345037, 0xFFDFF06F, 0xFE000CE3, 0x3002D073 -> out_imm sequence 0x12345000/3, 0xFFFFFFFC/4, 0xFFFFFFF8/2, 0x00000005/5 (imm/fmt).
REQ-039 out_ready=0, in_valid=1 for 3 cycles -> in_ready 1, 1, 0; the third word is held upstream; releasing out_ready drains the entries in order with correct out_pc.
REQ-040 count=FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the pushed word never appears.
REQ-041 Push 0x0000007F and then 0x00000000 -> out_fmt=6, out_imm=0, out_illegal=1 for both.
REQ-042 resetn pulsed low between edges while count=ONE -> out_valid=0 immediately; after release the next push emerges alone.
